// File: rtl/usb_tx_byte_buffer_if.sv
// Slave-side store / encoder-side pop bundle for the USB TX byte buffer.
// master drives stores and pops; slave (the buffer) returns head byte, count and flags.
interface usb_tx_byte_buffer_if #(
  parameter int unsigned CNT_W = 7
);
  logic             flush;
  logic             store_en;
  logic [1:0]       store_size;
  logic [31:0]      store_data;
  logic             get_byte;
  logic             clear_err;
  logic [7:0]       tx_byte;
  logic [CNT_W-1:0] occupancy;
  logic             empty;
  logic             full;
  logic             high_water;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output flush, store_en, store_size, store_data, get_byte, clear_err,
    input  tx_byte, occupancy, empty, full, high_water, overflow_err, underflow_err
  );

  modport slave (
    input  flush, store_en, store_size, store_data, get_byte, clear_err,
    output tx_byte, occupancy, empty, full, high_water, overflow_err, underflow_err
  );
endinterface

// File: rtl/usb_tx_byte_buffer.sv
// Byte FIFO between the AHB-Lite register file and the USB TX encoder: 1/2/4-byte
// little-endian stores in, first-word fall-through single bytes out, sticky error flags.
module usb_tx_byte_buffer #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1,
  parameter int unsigned HIGH_WATER = 48
) (
  input logic                 clk,
  input logic                 n_rst,
  usb_tx_byte_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CNT_W:0]   DepthExt  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HighWater = CNT_W'(HIGH_WATER);

  logic [7:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [2:0]       store_len;
  logic [3:0]       byte_we;
  logic [CNT_W:0]   occ_sum;
  logic             size_ok, fits, store_ok, get_ok, ovf_set, unf_set;

  always_comb begin
    store_len = 3'd0;
    byte_we   = 4'b0000;
    case (bus.store_size)
      2'd0:    store_len = 3'd1;
      2'd1:    store_len = 3'd2;
      2'd2:    store_len = 3'd4;
      default: store_len = 3'd0;
    endcase
    size_ok = (bus.store_size != 2'd3);
    // Capacity check uses pre-edge occupancy only; a simultaneous pop is not credited.
    occ_sum  = {1'b0, occ_q} + {{(CNT_W - 2){1'b0}}, store_len};
    fits     = (occ_sum <= DepthExt);
    store_ok = !bus.flush && bus.store_en && size_ok && fits;
    get_ok   = !bus.flush && bus.get_byte && (occ_q != '0);
    ovf_set  = !bus.flush && bus.store_en && !(size_ok && fits);
    unf_set  = !bus.flush && bus.get_byte && (occ_q == '0);

    if (store_ok) begin
      case (bus.store_size)
        2'd0:    byte_we = 4'b0001;
        2'd1:    byte_we = 4'b0011;
        default: byte_we = 4'b1111;
      endcase
    end

    if (bus.flush) begin
      rptr_d = '0;
      wptr_d = '0;
      occ_d  = '0;
    end else begin
      wptr_d = wptr_q + (store_ok ? PtrW'(store_len) : '0);
      rptr_d = rptr_q + PtrW'(get_ok);
      occ_d  = occ_q + (store_ok ? CNT_W'(store_len) : '0) - CNT_W'(get_ok);
    end

    ovf_d = ovf_set ? 1'b1 : (bus.clear_err ? 1'b0 : ovf_q);
    unf_d = unf_set ? 1'b1 : (bus.clear_err ? 1'b0 : unf_q);
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (byte_we[k]) begin
        mem_q[wptr_q + PtrW'(k)] <= bus.store_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign bus.tx_byte       = (occ_q == '0) ? 8'h00 : mem_q[rptr_q];
  assign bus.occupancy     = occ_q;
  assign bus.empty         = (occ_q == '0);
  assign bus.full          = (occ_q == DepthCnt);
  assign bus.high_water    = (occ_q >= HighWater);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;

endmodule
